// File: rtl/ps2_pkg.sv
// ps2_pkg
// Definitions shared between the PS/2 keyboard datapath blocks:
//   PS2_EXT / PS2_BRK : scancode prefix bytes (extended, break)
//   state_t           : sequencing FSM states of ps2_key_ctrl
//   key_event_t       : one decoded key event, reusable by downstream consumers
//   is_prefix()       : true for either prefix byte
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOOK = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] scancode;
        logic [7:0] ascii;
        logic       is_release;
        logic       extended;
    } key_event_t;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_EXT) || (b == PS2_BRK);
    endfunction

endpackage

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl
// Sits between the PS/2 byte receiver and an external scancode->ASCII ROM.
// Strips E0/F0 prefixes, looks the base code up in the ROM, and emits one
// key event per make/break code. Auto-repeat of the held key is dropped and
// make events are counted.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     scancode byte handshake from the receiver
//   in_data[7:0]          scancode byte
//   lut_code[7:0]         ROM address (registered)
//   lut_ascii[7:0]        ROM data, valid LUT_LAT cycles after lut_code
//   ev_valid/ev_ready     key event handshake to the consumer
//   ev_scancode/ev_ascii  base scancode and looked-up ASCII
//   ev_release            event is a key-up
//   ev_extended           code was E0-prefixed
//   key_held              a key is currently held
//   press_count[7:0]      emitted make events, mod 256
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int LUT_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] lut_code,
    input  logic [7:0] lut_ascii,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_scancode,
    output logic [7:0] ev_ascii,
    output logic       ev_release,
    output logic       ev_extended,
    output logic       key_held,
    output logic [7:0] press_count
);

    // LOOK lasts LUT_LAT+1 cycles: one for lut_code to reach the ROM
    // registers' view, LUT_LAT for the ROM itself.
    localparam logic [1:0] LAT_LAST = 2'(LUT_LAT);

    state_t     state_reg, state_next;
    logic [1:0] cnt_reg;
    logic       ext_f_reg, brk_f_reg;
    logic [7:0] held_code_reg;
    logic       held_ext_reg;
    logic       key_held_reg;
    logic [7:0] press_count_reg;
    logic [7:0] lut_code_reg;
    logic       ev_valid_reg;
    key_event_t ev_reg;

    logic accept;
    logic suppress;
    logic launch;
    logic brk_matches_held;

    // Gating with rst_n keeps in_ready low while reset is asserted even
    // though the state register already sits in IDLE.
    assign in_ready = rst_n && (state_reg == ST_IDLE);
    assign accept   = in_valid && in_ready;

    // Typematic repeat: a make code identical to the held key.
    assign suppress = key_held_reg && !brk_f_reg &&
                      (in_data == held_code_reg) && (ext_f_reg == held_ext_reg);
    assign launch   = accept && !is_prefix(in_data) && !suppress;

    assign brk_matches_held = key_held_reg &&
                              (ev_reg.scancode == held_code_reg) &&
                              (ev_reg.extended == held_ext_reg);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (launch)               state_next = ST_LOOK;
            ST_LOOK: if (cnt_reg == LAT_LAST)  state_next = ST_EMIT;
            ST_EMIT: if (ev_ready)             state_next = ST_IDLE;
            default:                           state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg         <= 2'd0;
            ext_f_reg       <= 1'b0;
            brk_f_reg       <= 1'b0;
            held_code_reg   <= 8'h00;
            held_ext_reg    <= 1'b0;
            key_held_reg    <= 1'b0;
            press_count_reg <= 8'h00;
            lut_code_reg    <= 8'h00;
            ev_valid_reg    <= 1'b0;
            ev_reg          <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (in_data == PS2_EXT) begin
                            ext_f_reg <= 1'b1;
                        end else if (in_data == PS2_BRK) begin
                            brk_f_reg <= 1'b1;
                        end else begin
                            // Flags are consumed by every base code,
                            // including a suppressed repeat.
                            ext_f_reg <= 1'b0;
                            brk_f_reg <= 1'b0;
                            if (!suppress) begin
                                lut_code_reg      <= in_data;
                                ev_reg.scancode   <= in_data;
                                ev_reg.is_release <= brk_f_reg;
                                ev_reg.extended   <= ext_f_reg;
                                cnt_reg           <= 2'd0;
                            end
                        end
                    end
                end
                ST_LOOK: begin
                    cnt_reg <= cnt_reg + 2'd1;
                    if (cnt_reg == LAT_LAST) begin
                        ev_reg.ascii <= lut_ascii;
                        ev_valid_reg <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (ev_ready) begin
                        ev_valid_reg <= 1'b0;
                        if (!ev_reg.is_release) begin
                            held_code_reg   <= ev_reg.scancode;
                            held_ext_reg    <= ev_reg.extended;
                            key_held_reg    <= 1'b1;
                            press_count_reg <= press_count_reg + 8'd1;
                        end else if (brk_matches_held) begin
                            key_held_reg <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign lut_code    = lut_code_reg;
    assign ev_valid    = ev_valid_reg;
    assign ev_scancode = ev_reg.scancode;
    assign ev_ascii    = ev_reg.ascii;
    assign ev_release  = ev_reg.is_release;
    assign ev_extended = ev_reg.extended;
    assign key_held    = key_held_reg;
    assign press_count = press_count_reg;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb_ps2_key_ctrl
// Directed and randomized bytes are pushed into ps2_key_ctrl one at a time;
// a behavioural model of the prefix/suppression/count rules predicts each
// event, which is compared field by field along with latency, backpressure
// behaviour, key_held and press_count.
module tb_ps2_key_ctrl;
    import ps2_pkg::*;

    localparam int LUT_LAT = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] lut_code;
    logic [7:0] lut_ascii;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_scancode;
    logic [7:0] ev_ascii;
    logic       ev_release;
    logic       ev_extended;
    logic       key_held;
    logic [7:0] press_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit         m_ext, m_brk, m_held_v, m_held_ext;
    logic [7:0] m_held_code;
    int         m_count;
    bit         saw_ff;

    ps2_key_ctrl #(.LUT_LAT(LUT_LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .lut_code    (lut_code),
        .lut_ascii   (lut_ascii),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_scancode (ev_scancode),
        .ev_ascii    (ev_ascii),
        .ev_release  (ev_release),
        .ev_extended (ev_extended),
        .key_held    (key_held),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_f(input logic [7:0] c);
        case (c)
            8'h1C:   return 8'h61;
            8'h15:   return 8'h71;
            8'h75:   return 8'h00;
            default: return c ^ 8'hA5;
        endcase
    endfunction

    // Registered ROM: one cycle latency
    always @(posedge clk) lut_ascii <= rom_f(lut_code);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_held_v = 0; m_held_ext = 0;
        m_held_code = 8'h00; m_count = 0;
    endtask

    // Predict the effect of one accepted byte.
    task automatic model_byte(input logic [7:0] b, output bit ev, output logic [17:0] exp);
        ev  = 0;
        exp = '0;
        if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (!m_brk && m_held_v && m_held_code == b && m_held_ext == m_ext) begin
                ev = 0;
            end else begin
                ev  = 1;
                exp = {b, rom_f(b), m_brk, m_ext};
                if (!m_brk) begin
                    m_held_v = 1; m_held_code = b; m_held_ext = m_ext;
                    m_count = (m_count + 1) % 256;
                end else if (m_held_v && m_held_code == b && m_held_ext == m_ext) begin
                    m_held_v = 0;
                end
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    // Offer one byte, run its event (if any) through to the handshake.
    // hold = cycles of ev_ready=0 after ev_valid rises (0: ev_ready tied high).
    // keep = leave in_valid high with byte 15 queued behind this one.
    task automatic do_byte(input logic [7:0] b, input int hold, input bit keep);
        bit          ev;
        logic [17:0] exp;
        int          n, k;
        ev_ready = (hold == 0);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("accept", 32'(in_ready), 1);
        model_byte(b, ev, exp);
        @(negedge clk);
        if (keep) in_data = 8'h15;
        else      in_valid = 1'b0;
        if (!ev) begin
            check_val("no_event", 32'(ev_valid), 0);
            check_val("one_cycle_ready", 32'(in_ready), 1);
            check_val("idle_count", 32'(press_count), 32'(m_count));
            check_val("idle_held", 32'(key_held), 32'(m_held_v));
        end else begin
            k = 1;
            check_val("look_ready", 32'(in_ready), 0);
            while (!ev_valid && k < 20) begin
                @(negedge clk);
                k++;
            end
            check_val("ev_rise", 32'(ev_valid), 1);
            check_val("latency", 32'(k), 32'(LUT_LAT + 2));
            for (int i = 0; i < hold; i++) begin
                check_val("bp_fields", 32'({ev_scancode, ev_ascii, ev_release, ev_extended}), 32'(exp));
                check_val("bp_valid", 32'(ev_valid), 1);
                check_val("bp_in_ready", 32'(in_ready), 0);
                @(negedge clk);
            end
            ev_ready = 1'b1;
            check_val("ev_fields", 32'({ev_scancode, ev_ascii, ev_release, ev_extended}), 32'(exp));
            @(negedge clk);
            ev_ready = 1'b0;
            check_val("ev_done", 32'(ev_valid), 0);
            check_val("count", 32'(press_count), 32'(m_count));
            check_val("held", 32'(key_held), 32'(m_held_v));
            check_val("back_idle", 32'(in_ready), 1);
            if (press_count == 8'hFF) saw_ff = 1;
        end
        $display("tx %02h event=%0d count=%0d held=%0d", b, ev, press_count, key_held);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        ev_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", 32'(in_ready), 0);
        check_val("rst_ev", 32'({ev_valid, ev_scancode, ev_ascii, ev_release, ev_extended}), 0);
        check_val("rst_misc", 32'({key_held, press_count, lut_code}), 0);
        rst_n = 1'b1;
        #1;
        check_val("post_rst_in_ready", 32'(in_ready), 1);
        check_val("post_rst_ev", 32'({ev_valid, ev_scancode, ev_ascii, ev_release, ev_extended}), 0);
        check_val("post_rst_misc", 32'({key_held, press_count, lut_code}), 0);
        model_reset();
        $display("tx reset");
    endtask

    // Launch a lookup, then reset while in LOOK (in_emit=0) or EMIT (in_emit=1).
    task automatic reset_mid(input logic [7:0] code, input bit in_emit);
        ev_ready = 1'b0;
        in_valid = 1'b1;
        in_data  = code;
        check_val("rm_accept", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        if (in_emit) repeat (LUT_LAT + 1) @(negedge clk);
        check_val("rm_state", 32'(ev_valid), 32'(in_emit));
        do_reset();
    endtask

    initial begin
        logic [7:0] rb;
        saw_ff = 0;
        model_reset();
        do_reset();

        // Make then break
        do_byte(8'h1C, 0, 0);
        do_byte(8'hF0, 0, 0);
        do_byte(8'h1C, 0, 0);

        // Typematic repeat
        do_byte(8'h1C, 0, 0);
        do_byte(8'h1C, 1, 0);
        do_byte(8'h1C, 0, 0);
        do_byte(8'hF0, 0, 0);
        do_byte(8'h1C, 2, 0);

        // Extended break, both prefix orders, with repeated prefixes
        do_byte(8'hE0, 0, 0);
        do_byte(8'hF0, 0, 0);
        do_byte(8'h75, 0, 0);
        do_byte(8'hF0, 0, 0);
        do_byte(8'hE0, 0, 0);
        do_byte(8'hE0, 0, 0);
        do_byte(8'h75, 0, 0);

        // Backpressure with the next byte waiting on in_valid
        do_byte(8'h1C, 10, 1);
        do_byte(8'h15, 0, 0);

        // press_count wrap from a clean start
        do_reset();
        for (int i = 0; i < 256; i++) begin
            rb = (i % 2 == 0) ? 8'h1C : 8'h15;
            do_byte(rb, 0, 0);
            do_byte(8'hF0, 0, 0);
            do_byte(rb, 0, 0);
        end
        check_val("wrap_zero", 32'(press_count), 0);
        check_val("wrap_saw_ff", 32'(saw_ff), 1);

        // Reset in LOOK and in EMIT
        reset_mid(8'h1C, 0);
        do_byte(8'h1C, 0, 0);
        reset_mid(8'h15, 1);
        do_byte(8'h1C, 1, 0);

        // Randomized byte stream
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 7))
                0:       rb = 8'h1C;
                1:       rb = 8'h15;
                2:       rb = 8'h75;
                3:       rb = 8'hE0;
                4:       rb = 8'hF0;
                default: rb = 8'($urandom);
            endcase
            do_byte(rb, int'($urandom_range(0, 3)), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
